bias_load: RTL and testbench



---
 rtl/bias_load_pkg.sv | 16 +
 rtl/bias_line_pack.sv | 57 +++++
 rtl/bias_load.sv | 109 ++++++++++
 tb/tb_bias_load.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bias_load_pkg.sv
// Shared definitions for the bias RAM loader: FSM state encodings and
// default beat/line geometry.
package bias_load_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int BEAT_WIDTH_DEF = 64;
    localparam int LINE_WIDTH_DEF = 512;
    localparam int BEATS_PER_LINE = LINE_WIDTH_DEF / BEAT_WIDTH_DEF;

endpackage

// File: rtl/bias_line_pack.sv
// Packs consecutive stream beats into one RAM line, beat 0 in the low bits.
// Raises o_line_full on the beat that completes the line.
module bias_line_pack #(
    parameter int BEAT_WIDTH = 64,
    parameter int LINE_WIDTH = 512
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    input  logic                  i_beat_en,
    input  logic [BEAT_WIDTH-1:0] i_beat_dat,
    output logic [LINE_WIDTH-1:0] o_line,
    output logic                  o_line_full
);

    localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CNT_W-1:0]      beat_cnt_q;
    logic [CNT_W-1:0]      beat_cnt_d;
    logic [LINE_WIDTH-1:0] line_q;
    logic [BEATS-1:0]      beat_we;

    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_we
            assign beat_we[gi] = i_beat_en && (beat_cnt_q == CNT_W'(gi));
        end
    endgenerate

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (i_clear) begin
            beat_cnt_d = '0;
        end else if (i_beat_en) begin
            beat_cnt_d = (beat_cnt_q == CNT_W'(BEATS - 1)) ? '0 : beat_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            beat_cnt_q <= '0;
            line_q     <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            for (int i = 0; i < BEATS; i++) begin
                if (beat_we[i]) begin
                    line_q[i*BEAT_WIDTH +: BEAT_WIDTH] <= i_beat_dat;
                end
            end
        end
    end

    assign o_line      = line_q;
    assign o_line_full = beat_we[BEATS-1];

endmodule

// File: rtl/bias_load.sv
// Bias RAM write-side loader: fills 512-bit lines from a 64-bit beat stream
// and writes them to consecutive addresses, yielding to the RAM reader.
module bias_load
    import bias_load_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 8,
    parameter int BEAT_WIDTH     = BEAT_WIDTH_DEF,
    parameter int LINE_WIDTH     = LINE_WIDTH_DEF
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_load_start,
    input  logic [RAM_ADDR_WIDTH-1:0] i_addr_start_b,
    input  logic [7:0]                i_line_num,
    input  logic [BEAT_WIDTH-1:0]     i_s_dat,
    input  logic                      i_s_vld,
    output logic                      o_s_rdy,
    input  logic                      i_ram_rd_en,
    output logic                      o_ram_wr_en,
    output logic [RAM_ADDR_WIDTH-1:0] o_ram_addr,
    output logic [LINE_WIDTH-1:0]     o_ram_dat,
    output logic                      o_load_busy,
    output logic                      o_load_done
);

    state_e                    state_q, state_d;
    logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]                lines_q, lines_d;
    logic                      pack_clear;
    logic                      beat_en;
    logic                      line_full;
    logic [LINE_WIDTH-1:0]     line_dat;

    assign beat_en = i_s_vld && (state_q == ST_FILL);

    bias_line_pack #(
        .BEAT_WIDTH (BEAT_WIDTH),
        .LINE_WIDTH (LINE_WIDTH)
    ) u_pack (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (pack_clear),
        .i_beat_en   (beat_en),
        .i_beat_dat  (i_s_dat),
        .o_line      (line_dat),
        .o_line_full (line_full)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        lines_d     = lines_q;
        pack_clear  = 1'b0;
        o_ram_wr_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_load_start) begin
                    addr_d  = i_addr_start_b;
                    lines_d = i_line_num;
                    if (i_line_num == 8'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        pack_clear = 1'b1;
                        state_d    = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if (line_full) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // The reader owns the single RAM port whenever it asks for it.
                o_ram_wr_en = ~i_ram_rd_en;
                if (!i_ram_rd_en) begin
                    addr_d  = addr_q + RAM_ADDR_WIDTH'(1);
                    lines_d = lines_q - 8'd1;
                    state_d = (lines_q == 8'd1) ? ST_DONE : ST_FILL;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            lines_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lines_q <= lines_d;
        end
    end

    assign o_s_rdy     = (state_q == ST_FILL);
    assign o_ram_addr  = addr_q;
    assign o_ram_dat   = line_dat;
    assign o_load_busy = (state_q != ST_IDLE);
    assign o_load_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_bias_load.sv
// Self-checking bench for bias_load: randomized loads compared against a
// line-level model of expected writes, stream handshakes and completion.
module tb_bias_load;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_load_start;
    logic [7:0]   i_addr_start_b;
    logic [7:0]   i_line_num;
    logic [63:0]  i_s_dat;
    logic         i_s_vld;
    logic         o_s_rdy;
    logic         i_ram_rd_en;
    logic         o_ram_wr_en;
    logic [7:0]   o_ram_addr;
    logic [511:0] o_ram_dat;
    logic         o_load_busy;
    logic         o_load_done;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    bias_load #(
        .RAM_ADDR_WIDTH (8),
        .BEAT_WIDTH     (64),
        .LINE_WIDTH     (512)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_load_start   (i_load_start),
        .i_addr_start_b (i_addr_start_b),
        .i_line_num     (i_line_num),
        .i_s_dat        (i_s_dat),
        .i_s_vld        (i_s_vld),
        .o_s_rdy        (o_s_rdy),
        .i_ram_rd_en    (i_ram_rd_en),
        .o_ram_wr_en    (o_ram_wr_en),
        .o_ram_addr     (o_ram_addr),
        .o_ram_dat      (o_ram_dat),
        .o_load_busy    (o_load_busy),
        .o_load_done    (o_load_done)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy"},   o_s_rdy,     1'b0);
        chk({tag, "_wr"},    o_ram_wr_en, 1'b0);
        chk({tag, "_addr"},  o_ram_addr,  8'h00);
        chk({tag, "_dat"},   o_ram_dat,   512'h0);
        chk({tag, "_busy"},  o_load_busy, 1'b0);
        chk({tag, "_done"},  o_load_done, 1'b0);
    endtask

    // One complete load: the model knows which line each beat belongs to and
    // where each line must land; it predicts ready, write, and done per cycle.
    task automatic do_load(input logic [7:0] base, input int n, input bit seq,
                           input int vld_pct, input int rd_pct, input int stall_k,
                           input bit poke);
        logic [63:0]  beats[$];
        logic [511:0] exp_dat[$];
        logic [7:0]   exp_addr[$];
        logic [511:0] line;
        int accepted   = 0;
        int writes     = 0;
        int stall_left = 0;
        int cyc        = 0;
        int budget     = 400 + n * 200;
        bit done_next;
        bit finished   = 1'b0;
        bit pending, exp_rdy, exp_wr;

        for (int i = 0; i < n * 8; i++) begin
            beats.push_back(seq ? 64'(i) : {$urandom, $urandom});
        end
        for (int l = 0; l < n; l++) begin
            line = '0;
            for (int b = 0; b < 8; b++) line[b*64 +: 64] = beats[l*8 + b];
            exp_dat.push_back(line);
            exp_addr.push_back(base + 8'(l));
        end
        done_next = (n == 0);

        i_addr_start_b = base;
        i_line_num     = 8'(n);
        i_load_start   = 1'b1;
        i_s_vld        = 1'b0;
        i_ram_rd_en    = 1'b0;
        @(negedge i_clk);
        chk("start_idle_busy", o_load_busy, 1'b0);
        @(posedge i_clk); #1;
        i_load_start = 1'b0;

        while (!finished && cyc < budget) begin
            i_load_start = poke && (cyc == ((n == 0) ? 0 : 5));
            if (i_load_start) begin
                i_addr_start_b = 8'h99;
                i_line_num     = 8'd5;
            end
            if (accepted < n * 8) begin
                i_s_vld = ($urandom_range(99) < vld_pct);
                i_s_dat = beats[accepted];
            end else begin
                i_s_vld = 1'($urandom_range(1));
                i_s_dat = {$urandom, $urandom};
            end
            if (stall_left > 0) begin
                i_ram_rd_en = 1'b1;
                stall_left--;
            end else begin
                i_ram_rd_en = ($urandom_range(99) < rd_pct);
            end

            @(negedge i_clk);
            pending = (accepted / 8) > writes;
            exp_rdy = !pending && (accepted < n * 8);
            exp_wr  = pending && !i_ram_rd_en;
            chk("busy", o_load_busy, 1'b1);
            chk("s_rdy", o_s_rdy, exp_rdy);
            chk("wr_en", o_ram_wr_en, exp_wr);
            chk("done", o_load_done, done_next);
            if (pending) begin
                chk("wr_addr", o_ram_addr, exp_addr[0]);
                chk("wr_dat", o_ram_dat, exp_dat[0]);
            end
            finished  = done_next;
            done_next = 1'b0;
            if (exp_wr) begin
                void'(exp_addr.pop_front());
                void'(exp_dat.pop_front());
                writes++;
                if (writes == n) done_next = 1'b1;
            end
            if (exp_rdy && i_s_vld) begin
                accepted++;
                if (accepted % 8 == 0) stall_left = stall_k;
            end
            cyc++;
            @(posedge i_clk); #1;
        end
        chk("load_finished", finished, 1'b1);

        i_load_start = 1'b0;
        i_s_vld      = 1'b0;
        i_ram_rd_en  = 1'b0;
        @(negedge i_clk);
        chk("after_busy", o_load_busy, 1'b0);
        chk("after_rdy", o_s_rdy, 1'b0);
        chk("after_done", o_load_done, 1'b0);
        chk("after_wr", o_ram_wr_en, 1'b0);
        $display("load base=%02h lines=%0d writes=%0d cycles=%0d stall=%0d", base, n, writes, cyc, stall_k);
        @(posedge i_clk); #1;
    endtask

    initial begin
        i_rst          = 1'b1;
        i_load_start   = 1'b0;
        i_addr_start_b = 8'h00;
        i_line_num     = 8'd0;
        i_s_dat        = 64'h0;
        i_s_vld        = 1'b0;
        i_ram_rd_en    = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        @(negedge i_clk);
        chk_reset_vals("reset");
        $display("reset check done");
        @(posedge i_clk); #1;
        i_rst = 1'b0;

        do_load(8'h10, 1, 1'b1, 100, 0, 0, 1'b0);
        do_load(8'h20, 3, 1'b0, 50, 0, 0, 1'b0);
        do_load(8'h30, 2, 1'b0, 100, 0, 4, 1'b1);
        do_load(8'hFF, 2, 1'b0, 70, 30, 0, 1'b0);
        do_load(8'h55, 0, 1'b0, 100, 0, 0, 1'b1);

        // Abandon a load after 5 beats; nothing may reach the RAM.
        i_addr_start_b = 8'h40;
        i_line_num     = 8'd1;
        i_load_start   = 1'b1;
        @(posedge i_clk); #1;
        i_load_start = 1'b0;
        i_s_vld      = 1'b1;
        for (int b = 0; b < 5; b++) begin
            i_s_dat = {$urandom, $urandom};
            @(negedge i_clk);
            chk("midfill_rdy", o_s_rdy, 1'b1);
            chk("midfill_wr", o_ram_wr_en, 1'b0);
            @(posedge i_clk); #1;
        end
        i_s_vld = 1'b0;
        i_rst   = 1'b1;
        @(posedge i_clk); #1;
        @(negedge i_clk);
        chk_reset_vals("midfill_reset");
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk_reset_vals("post_reset_idle");
        $display("reset mid-fill after 5 beats");
        @(posedge i_clk); #1;
        do_load(8'h40, 1, 1'b0, 100, 0, 0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            do_load(8'($urandom), int'($urandom_range(1, 4)), 1'b0,
                    int'($urandom_range(30, 100)), int'($urandom_range(0, 40)),
                    int'($urandom_range(0, 3)), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
